// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen: raster timing generator feeding three TMDS encoder
// channels. Free-running h/v counters produce registered de/hsync/vsync/sof,
// the active-pixel coordinates and the per-channel pixel bytes.
// Optional build macro COLOR_BAR_EN replaces the external pixel source with
// eight internal vertical colour bars (px_data_i is then ignored and
// px_req_o stays low).
module hdmi_video_timing_gen #(
    parameter int   H_ACTIVE   = 1920,
    parameter int   H_FP       = 88,
    parameter int   H_SYNC     = 44,
    parameter int   H_BP       = 148,
    parameter int   V_ACTIVE   = 1080,
    parameter int   V_FP       = 4,
    parameter int   V_SYNC     = 5,
    parameter int   V_BP       = 36,
    parameter logic H_SYNC_POL = 1'b1,
    parameter logic V_SYNC_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic [23:0] px_data_i,
    output logic        px_req_o,
    output logic [7:0]  r_o,
    output logic [7:0]  g_o,
    output logic [7:0]  b_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        sof_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_L       = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG_L  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END_L  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST_L      = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_L       = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG_L  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END_L  = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST_L      = 12'(V_TOTAL - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic [11:0] h_cnt_r;
    logic [11:0] v_cnt_r;
    logic        run_s;
    logic        active_s;
    logic        hsync_act_s;
    logic        vsync_act_s;
    logic        origin_s;
    logic [23:0] pixel_s;

    // Decode the raster position of the current counter state.
    always_comb begin
        run_s       = (state_r == RUN);
        active_s    = run_s && (h_cnt_r < H_ACT_L) && (v_cnt_r < V_ACT_L);
        hsync_act_s = run_s && (h_cnt_r >= H_SYNC_BEG_L) && (h_cnt_r < H_SYNC_END_L);
        vsync_act_s = run_s && (v_cnt_r >= V_SYNC_BEG_L) && (v_cnt_r < V_SYNC_END_L);
        origin_s    = (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
    end

`ifdef COLOR_BAR_EN
    localparam logic [11:0] BAR_W_M1_L = 12'((H_ACTIVE / 8) - 1);

    logic [2:0]  bar_idx_r;
    logic [11:0] bar_left_r;
    logic [23:0] unused_px_s;

    // Fixed bar palette, {r,g,b}, white down to black.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Bar tracker: down-counter reloaded at each line start, so no divider is
    // needed; remainder pixels past the eighth bar simply stay in bar 7.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bar_idx_r  <= 3'd0;
            bar_left_r <= BAR_W_M1_L;
        end else if (!run_s || (h_cnt_r == H_LAST_L)) begin
            bar_idx_r  <= 3'd0;
            bar_left_r <= BAR_W_M1_L;
        end else if (bar_left_r != 12'd0) begin
            bar_left_r <= bar_left_r - 12'd1;
        end else if (bar_idx_r != 3'd7) begin
            bar_idx_r  <= bar_idx_r + 3'd1;
            bar_left_r <= BAR_W_M1_L;
        end else begin
            bar_idx_r  <= bar_idx_r;
            bar_left_r <= bar_left_r;
        end
    end

    assign unused_px_s = px_data_i;
    assign pixel_s     = bar_color(bar_idx_r);
    assign px_req_o    = 1'b0;
`else
    assign pixel_s  = px_data_i;
    assign px_req_o = active_s;
`endif

    // Run/idle FSM with the h/v counters and every registered video output;
    // leaving RUN is only possible on the last cycle of a frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            h_cnt_r <= 12'd0;
            v_cnt_r <= 12'd0;
            de_o    <= 1'b0;
            sof_o   <= 1'b0;
            hsync_o <= ~H_SYNC_POL;
            vsync_o <= ~V_SYNC_POL;
            x_o     <= 12'd0;
            y_o     <= 12'd0;
            r_o     <= 8'd0;
            g_o     <= 8'd0;
            b_o     <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    h_cnt_r <= 12'd0;
                    v_cnt_r <= 12'd0;
                    if (en_i) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (h_cnt_r == H_LAST_L) begin
                        h_cnt_r <= 12'd0;
                        if (v_cnt_r == V_LAST_L) begin
                            v_cnt_r <= 12'd0;
                            if (en_i) begin
                                state_r <= RUN;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            v_cnt_r <= v_cnt_r + 12'd1;
                        end
                    end else begin
                        h_cnt_r <= h_cnt_r + 12'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    h_cnt_r <= 12'd0;
                    v_cnt_r <= 12'd0;
                end
            endcase

            de_o    <= active_s;
            sof_o   <= active_s && origin_s;
            hsync_o <= hsync_act_s ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_o <= vsync_act_s ? V_SYNC_POL : ~V_SYNC_POL;
            x_o     <= active_s ? h_cnt_r : 12'd0;
            y_o     <= active_s ? v_cnt_r : 12'd0;
            r_o     <= active_s ? pixel_s[23:16] : 8'd0;
            g_o     <= active_s ? pixel_s[15:8]  : 8'd0;
            b_o     <= active_s ? pixel_s[7:0]   : 8'd0;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench for hdmi_video_timing_gen on a small raster
// (H 8/2/2/2, V 4/1/1/1; H active 16 when COLOR_BAR_EN is defined).
module tb_hdmi_video_timing_gen;
`ifdef COLOR_BAR_EN
    localparam int   HA   = 16;
    localparam logic BARS = 1'b1;
`else
    localparam int   HA   = 8;
    localparam logic BARS = 1'b0;
`endif
    localparam int HT    = HA + 6;
    localparam int VT    = 7;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic [23:0] px_data_i;
    logic        px_req_o;
    logic [7:0]  r_o;
    logic [7:0]  g_o;
    logic [7:0]  b_o;
    logic        de_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        sof_o;
    logic [11:0] x_o;
    logic [11:0] y_o;

    int          checks   = 0;
    int          failures = 0;
    logic        run_m    = 1'b0;
    int          k_m      = 0;
    logic        en_cur   = 1'b0;
    logic [23:0] px_cur   = 24'h0;
    int          pxv      = 0;
    int          guard    = 0;
    logic [23:0] bar_tab [8];

    hdmi_video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .en_i(en_i), .px_data_i(px_data_i),
        .px_req_o(px_req_o), .r_o(r_o), .g_o(g_o), .b_o(b_o), .de_o(de_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .sof_o(sof_o), .x_o(x_o), .y_o(y_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the frame model with the en_i seen at the posedge,
    // compare every output, then drive the next inputs.
    task automatic cycle(input logic en_next, input logic [23:0] px_next);
        logic        p_run;
        logic        p_act;
        logic        act;
        int          p_k;
        int          ph;
        int          pv;
        int          h;
        int          v;
        int          bi;
        logic [23:0] p_pix;
        @(negedge clk);
        p_run = run_m;
        p_k   = k_m;
        if (!run_m) begin
            if (en_cur) begin
                run_m = 1'b1;
                k_m   = 0;
            end
        end else if (k_m == FRAME - 1) begin
            k_m = 0;
            if (!en_cur) run_m = 1'b0;
        end else begin
            k_m++;
        end
        ph    = p_k % HT;
        pv    = p_k / HT;
        h     = k_m % HT;
        v     = k_m / HT;
        p_act = p_run && (ph < HA) && (pv < 4);
        act   = run_m && (h < HA) && (v < 4);
        bi    = ph / (HA / 8);
        if (bi > 7) bi = 7;
        p_pix = BARS ? bar_tab[bi] : px_cur;
        chk("px_req", 32'(px_req_o), 32'(act && !BARS));
        chk("de",     32'(de_o),     32'(p_act));
        chk("hsync",  32'(hsync_o),  32'(p_run && (ph >= HA + 2) && (ph < HA + 4)));
        chk("vsync",  32'(vsync_o),  32'(p_run && (pv == 5)));
        chk("sof",    32'(sof_o),    32'(p_act && (ph == 0) && (pv == 0)));
        chk("x",      32'(x_o),      p_act ? 32'(ph) : 32'd0);
        chk("y",      32'(y_o),      p_act ? 32'(pv) : 32'd0);
        chk("rgb",    32'({r_o, g_o, b_o}), p_act ? 32'(p_pix) : 32'd0);
        en_i      = en_next;
        px_data_i = px_next;
        en_cur    = en_next;
        px_cur    = px_next;
    endtask

    initial begin
        bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        rst_n_i   = 1'b0;
        en_i      = 1'b0;
        px_data_i = 24'h0;
        repeat (3) @(negedge clk);
        chk("reset_de",     32'(de_o),     32'd0);
        chk("reset_hsync",  32'(hsync_o),  32'd0);
        chk("reset_vsync",  32'(vsync_o),  32'd0);
        chk("reset_px_req", 32'(px_req_o), 32'd0);
        rst_n_i = 1'b1;

        // Idle with en_i low: everything stays deasserted.
        repeat (50) cycle(1'b0, 24'h0);

        // Two full frames plus the start of a third, incrementing pixels.
        for (int i = 0; i < 2 * FRAME + 22; i++) begin
            pxv++;
            cycle(1'b1, 24'h100000 + 24'(pxv * 3));
        end

        // Drop en_i on line 1: the frame must finish, then idle.
        for (int i = 0; i < FRAME; i++) begin
            pxv++;
            cycle(1'b0, 24'h200000 + 24'(pxv * 5));
        end

        // Re-enable: restart from (0,0).
        for (int i = 0; i < FRAME + 10; i++) begin
            pxv++;
            cycle(1'b1, 24'h300000 + 24'(pxv * 7));
        end

        // Advance to an active pixel on line 2, then hit async reset mid-cycle.
        guard = 0;
        while (!(run_m && (k_m == 2 * HT + 2)) && (guard < 2 * FRAME)) begin
            pxv++;
            cycle(1'b1, 24'h400000 + 24'(pxv));
            guard++;
        end
        rst_n_i = 1'b0;
        #1;
        chk("arst_de",     32'(de_o),     32'd0);
        chk("arst_sof",    32'(sof_o),    32'd0);
        chk("arst_px_req", 32'(px_req_o), 32'd0);
        chk("arst_hsync",  32'(hsync_o),  32'd0);
        chk("arst_vsync",  32'(vsync_o),  32'd0);
        chk("arst_x",      32'(x_o),      32'd0);
        chk("arst_y",      32'(y_o),      32'd0);
        chk("arst_rgb",    32'({r_o, g_o, b_o}), 32'd0);
        repeat (2) @(negedge clk);
        run_m   = 1'b0;
        k_m     = 0;
        rst_n_i = 1'b1;

        // Restart after reset: first de pixel is (0,0).
        for (int i = 0; i < FRAME + 10; i++) begin
            pxv++;
            cycle(1'b1, 24'h500000 + 24'(pxv * 11));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
